// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM audio path: default widths and the interpolator FSM states.
package pdm_pkg;

  localparam int PDM_N     = 16;
  localparam int PDM_K     = 6;
  localparam int PDM_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pdm_sample_interp_if.sv
// Sample input handshake for the PDM interpolator: valid/ready plus the unsigned sample.
interface pdm_sample_interp_if #(
  parameter int N = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/pdm_sample_fifo.sv
// Small show-ahead FIFO for incoming samples; flags come from a registered occupancy count.
module pdm_sample_fifo
  import pdm_pkg::*;
#(
  parameter int N     = PDM_N,
  parameter int DEPTH = PDM_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  input  logic [N-1:0] wr_data,
  output logic         wr_ready,
  input  logic         rd_en,
  output logic [N-1:0] rd_data,
  output logic         empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push;
  logic          pop;

  assign wr_ready = (count_reg < FULL_CNT);
  assign empty    = (count_reg == '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && !empty;
  // Head entry is presented combinationally so a pop consumes it in the same cycle.
  assign rd_data  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pdm_sample_interp.sv
// Linear interpolator feeding the PDM modulator: one new level per clock, one sample per 2^K enabled clocks.
module pdm_sample_interp
  import pdm_pkg::*;
#(
  parameter int N     = PDM_N,
  parameter int K     = PDM_K,
  parameter int DEPTH = PDM_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  pdm_sample_interp_if.slave   in_if,
  output logic [N-1:0]         out_level,
  output logic                 underrun,
  output logic                 running
);

  localparam logic [K-1:0] PHASE_LAST = '1;

  state_t              state_reg;
  logic [N-1:0]        prev_reg;
  logic [N-1:0]        cur_reg;
  logic [N-1:0]        level_reg;
  logic [K-1:0]        phase_reg;
  logic                underrun_reg;

  logic                fifo_empty;
  logic [N-1:0]        fifo_rd_data;
  logic                boundary;
  logic                pop;

  logic signed [N:0]       diff;
  logic signed [N+K+1:0]   diff_ext;
  logic signed [N+K+1:0]   phase_ext;
  logic signed [N+K+1:0]   product;
  logic signed [N+K+1:0]   shifted;
  logic [N-1:0]            level_next;
  logic                    unused_shift_bits;

  assign boundary = (state_reg == RUN) && en && (phase_reg == PHASE_LAST);
  assign pop      = en && !fifo_empty && ((state_reg == IDLE) || boundary);

  pdm_sample_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_if.in_valid),
    .wr_data  (in_if.in_data),
    .wr_ready (in_if.in_ready),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty)
  );

  // Arithmetic shift floors toward -inf, so the sum stays between prev and cur and fits N bits.
  assign diff              = $signed({1'b0, cur_reg}) - $signed({1'b0, prev_reg});
  assign diff_ext          = {{(K+1){diff[N]}}, diff};
  assign phase_ext         = {{(N+2){1'b0}}, phase_reg};
  assign product           = diff_ext * phase_ext;
  assign shifted           = product >>> K;
  assign level_next        = prev_reg + shifted[N-1:0];
  assign unused_shift_bits = ^shifted[N+K+1:N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      prev_reg     <= '0;
      cur_reg      <= '0;
      level_reg    <= '0;
      phase_reg    <= '0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      if (en) begin
        case (state_reg)
          IDLE: begin
            if (!fifo_empty) begin
              cur_reg   <= fifo_rd_data;
              phase_reg <= '0;
              state_reg <= RUN;
            end
          end
          RUN: begin
            level_reg <= level_next;
            phase_reg <= phase_reg + K'(1);
            if (boundary) begin
              prev_reg <= cur_reg;
              if (!fifo_empty) begin
                cur_reg <= fifo_rd_data;
              end else begin
                underrun_reg <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign out_level = level_reg;
  assign underrun  = underrun_reg;
  assign running   = (state_reg == RUN);

endmodule

// File: tb/tb_pdm_sample_interp.sv
// Directed and randomized checks of the PDM sample interpolator against a ramp-stream reference model.
module tb_pdm_sample_interp;

  localparam int N     = 16;
  localparam int K     = 2;
  localparam int DEPTH = 4;
  localparam int P     = 1 << K;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [N-1:0] out_level;
  logic         underrun;
  logic         running;

  pdm_sample_interp_if #(.N(N)) in_if ();

  pdm_sample_interp #(
    .N     (N),
    .K     (K),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_if     (in_if),
    .out_level (out_level),
    .underrun  (underrun),
    .running   (running)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  bit           stream_on = 1'b0;
  int           adv_j = 0;
  logic [N-1:0] acc_q [$];
  logic [N-1:0] last_out = '0;

  logic [N-1:0] ramp_exp  [16] = '{16'h0000, 16'h0400, 16'h0800, 16'h0C00,
                                   16'h1000, 16'h0E00, 16'h0C00, 16'h0A00,
                                   16'h0800, 16'h0800, 16'h0800, 16'h0800,
                                   16'h0800, 16'h0E00, 16'h1400, 16'h1A00};
  logic [N-1:0] floor_exp [10] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002,
                                   16'h0003, 16'h0002, 16'h0001, 16'h0000,
                                   16'h0000, 16'h0000};

  // Point on the straight line from p to c at fraction ph/P, rounded toward -inf.
  function automatic int ref_level(input int p, input int c, input int ph);
    int num;
    int q;
    num = (c - p) * ph;
    if (num >= 0) q = num / P;
    else          q = -((-num + P - 1) / P);
    return p + q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; records accepted pushes and, when enabled, checks the output stream.
  task automatic tick();
    bit           adv;
    bit           pushed;
    logic [N-1:0] pdata;
    int           seg;
    int           ph;
    int           sz;
    int           p;
    int           c;
    adv    = running && en && !rst;
    pushed = in_if.in_valid && in_if.in_ready && !rst;
    pdata  = in_if.in_data;
    @(posedge clk);
    #2;
    if (pushed) acc_q.push_back(pdata);
    if (stream_on) begin
      if (adv) begin
        seg = adv_j / P;
        ph  = adv_j % P;
        sz  = acc_q.size();
        c   = (seg < sz) ? int'(acc_q[seg]) : ((sz > 0) ? int'(acc_q[sz-1]) : 0);
        p   = (seg == 0) ? 0 : ((seg - 1 < sz) ? int'(acc_q[seg-1]) : c);
        chk("stream_level", out_level, ref_level(p, c, ph));
        adv_j++;
      end else begin
        chk("stream_hold", out_level, last_out);
      end
      chk("stream_underrun", underrun, 0);
    end
    last_out = out_level;
  endtask

  task automatic clear_model();
    acc_q.delete();
    adv_j    = 0;
    last_out = '0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stream_on      = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
  endtask

  // Ramp from reset, then underrun and resume; expects to start right after reset release.
  task automatic ramp_test();
    chk("rst_level", out_level, 0);
    chk("rst_ready", in_if.in_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_underrun", underrun, 0);
    en             = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 16'h1000;
    tick();
    chk("idle_running", running, 0);
    in_if.in_data = 16'h0800;
    tick();
    chk("run_entered", running, 1);
    in_if.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("ramp_level", out_level, ramp_exp[i]);
      chk("ramp_underrun", underrun, (i == 7) || (i == 15));
      if (i == 8) begin
        in_if.in_valid = 1'b1;
        in_if.in_data  = 16'h2000;
      end else begin
        in_if.in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;

    // Ramp from reset plus underrun and resume
    do_reset();
    ramp_test();

    // Floor rounding on a falling ramp
    do_reset();
    in_if.in_valid = 1'b1;
    in_if.in_data  = 16'h0003;
    tick();
    in_if.in_data  = 16'h0000;
    tick();
    in_if.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("floor_level", out_level, floor_exp[i]);
      chk("floor_underrun", underrun, i == 7);
    end

    // Full FIFO with en held low, then drain in order
    do_reset();
    en        = 1'b0;
    stream_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_if.in_valid = 1'b1;
      in_if.in_data  = N'($urandom);
      tick();
    end
    chk("full_ready", in_if.in_ready, 0);
    chk("full_running", running, 0);
    in_if.in_data = N'($urandom);
    tick();
    chk("full_ready_held", in_if.in_ready, 0);
    en = 1'b1;
    for (int w = 0; w < 10 && acc_q.size() < 5; w++) tick();
    chk("fifth_accepted", acc_q.size(), 5);
    for (int i = 0; i < 14; i++) begin
      in_if.in_data = N'($urandom);
      tick();
    end

    // Enable stall mid-period
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_running", running, 1);
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_if.in_data = N'($urandom);
      tick();
    end

    // Randomized enable and push pattern
    for (int i = 0; i < 300; i++) begin
      en             = ($urandom_range(0, 3) != 0);
      in_if.in_valid = (i < 8) || ($urandom_range(0, 3) != 0);
      in_if.in_data  = N'($urandom);
      tick();
    end

    // Asynchronous reset between clock edges, then the ramp again
    en             = 1'b1;
    in_if.in_valid = 1'b0;
    stream_on      = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_level", out_level, 0);
    chk("async_running", running, 0);
    chk("async_ready", in_if.in_ready, 1);
    chk("async_underrun", underrun, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    ramp_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
